// File: rtl/decodeur_clavier.sv
// PS/2 keyboard receiver: filters the keyboard clock, deframes bytes and keeps
// held-key flags for two players (WASD for player 1, extended arrows for player 2).
module decodeur_clavier #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic j1_up,
    output logic j1_down,
    output logic j1_left,
    output logic j1_right,
    output logic j2_up,
    output logic j2_down,
    output logic j2_left,
    output logic j2_right,
    output logic frame_err
);
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          w_change, w_fall;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic          r_par_ok, w_par_ok_nxt;
    logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic          r_byte_valid, w_byte_valid_nxt;
    logic          r_frame_err, w_frame_err_nxt;

    logic          r_ext, r_brk;
    logic [7:0]    r_keys;
    logic [7:0]    w_key_hit;

    // Two-flop synchronizers followed by a run-length glitch filter on the clock
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
            r_filt     <= 1'b0;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (w_change) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_change = (r_clk_s2 != r_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall   = w_change && r_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_par_ok     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_par_ok     <= w_par_ok_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_par_ok_nxt     = r_par_ok;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_to_cnt_nxt     = (r_state == S_IDLE || w_fall) ? '0 : r_to_cnt + TW'(1);
        case (r_state)
            S_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_par_ok_nxt = (^r_shift) ^ r_dat_s2;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_byte_valid_nxt = r_dat_s2 && r_par_ok;
                    w_frame_err_nxt  = !(r_dat_s2 && r_par_ok);
                    w_state_nxt      = S_IDLE;
                end
            end
        endcase
        // A stalled partial frame is abandoned
        if (r_state != S_IDLE && !w_fall && r_to_cnt == TW'(TIMEOUT - 1)) begin
            w_state_nxt     = S_IDLE;
            w_frame_err_nxt = 1'b1;
            w_to_cnt_nxt    = '0;
        end
    end

    // Direction key selected by the received byte under the current ext prefix
    always_comb begin
        w_key_hit = '0;
        if (!r_ext) begin
            case (r_shift)
                8'h1D:   w_key_hit = 8'b1000_0000;
                8'h1B:   w_key_hit = 8'b0100_0000;
                8'h1C:   w_key_hit = 8'b0010_0000;
                8'h23:   w_key_hit = 8'b0001_0000;
                default: w_key_hit = '0;
            endcase
        end else begin
            case (r_shift)
                8'h75:   w_key_hit = 8'b0000_1000;
                8'h72:   w_key_hit = 8'b0000_0100;
                8'h6B:   w_key_hit = 8'b0000_0010;
                8'h74:   w_key_hit = 8'b0000_0001;
                default: w_key_hit = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_keys <= '0;
        end else if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
                r_keys <= r_brk ? (r_keys & ~w_key_hit) : (r_keys | w_key_hit);
            end
        end
    end

    assign j1_up     = r_keys[7];
    assign j1_down   = r_keys[6];
    assign j1_left   = r_keys[5];
    assign j1_right  = r_keys[4];
    assign j2_up     = r_keys[3];
    assign j2_down   = r_keys[2];
    assign j2_left   = r_keys[1];
    assign j2_right  = r_keys[0];
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_decodeur_clavier.sv
// Bench for decodeur_clavier: PS/2 frames driven bit by bit, outputs checked every
// cycle against a frame/byte-level model of the keyboard protocol.
module tb_decodeur_clavier;
    localparam int FL  = 4;
    localparam int TO  = 300;
    localparam int LAT = FL + 2;   // drive cycle of a falling ps2_clk -> cycle the receiver acts on it
    localparam int HN  = 200000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic j1_up, j1_down, j1_left, j1_right;
    logic j2_up, j2_down, j2_left, j2_right;
    logic frame_err;
    logic [7:0] w_keys;

    decodeur_clavier #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .j1_up(j1_up), .j1_down(j1_down), .j1_left(j1_left), .j1_right(j1_right),
        .j2_up(j2_up), .j2_down(j2_down), .j2_left(j2_left), .j2_right(j2_right),
        .frame_err(frame_err)
    );

    assign w_keys = {j1_up, j1_down, j1_left, j1_right, j2_up, j2_down, j2_left, j2_right};

    initial forever #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        rst_seen = reset;
    end

    typedef struct {
        int   t;
        logic d;
    } edge_t;
    edge_t eq[$];

    int tests = 0;
    int fails = 0;
    int errcnt = 0;
    int last_fall_c = 0;
    logic [7:0] hist_keys [0:HN-1];

    // Model state: held keys, prefixes and the frame being collected
    logic [7:0] m_keys = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_in = 1'b0;
    int         m_n = 0;
    int         m_last = 0;
    logic [9:0] m_bits = '0;

    logic [7:0] p1_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] p2_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] pool [13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hE1};

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [7:0] hit;
        hit = 8'h00;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!m_ext && b == p1_codes[i]) hit = 8'h80 >> i;
                if (m_ext && b == p2_codes[i])  hit = 8'h08 >> i;
            end
            if (m_brk) m_keys = m_keys & ~hit;
            else       m_keys = m_keys | hit;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic m_edge(input logic d, input int n, inout logic err);
        if (!m_in) begin
            if (d == 1'b0) begin
                m_in = 1'b1;
                m_n = 0;
                m_last = n;
            end
        end else begin
            m_bits[m_n] = d;
            m_n = m_n + 1;
            m_last = n;
            if (m_n == 10) begin
                m_in = 1'b0;
                if ((^m_bits[8:0]) == 1'b1 && m_bits[9] == 1'b1) begin
                    m_byte(m_bits[7:0]);
                end else begin
                    err = 1'b1;
                    m_ext = 1'b0;
                    m_brk = 1'b0;
                end
            end
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    initial forever begin
        logic [7:0] exp_keys;
        logic       exp_err;
        edge_t      e;
        @(negedge clk);
        exp_keys = m_keys;
        exp_err = 1'b0;
        if (rst_seen) begin
            m_keys = 8'h00;
            m_ext = 1'b0;
            m_brk = 1'b0;
            m_in = 1'b0;
            exp_keys = 8'h00;
            eq.delete();
        end else begin
            if (m_in && cyc == m_last + TO) begin
                exp_err = 1'b1;
                m_in = 1'b0;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            while (eq.size() > 0 && eq[0].t <= cyc) begin
                e = eq.pop_front();
                if (e.t == cyc) m_edge(e.d, cyc, exp_err);
            end
        end
        chk("keys", w_keys, exp_keys);
        chk("frame_err", 8'(frame_err), 8'(exp_err));
        if (cyc < HN) hist_keys[cyc] = w_keys;
        if (frame_err === 1'b1) errcnt = errcnt + 1;
    end

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic d, input int h, input bit g);
        edge_t e;
        ps2_data = d;
        if (g) begin
            wait_cyc(6); ps2_clk = 1'b0; wait_cyc(1); ps2_clk = 1'b1; wait_cyc(h - 7);
        end else begin
            wait_cyc(h);
        end
        ps2_clk = 1'b0;
        e.t = cyc + LAT;
        e.d = d;
        eq.push_back(e);
        last_fall_c = cyc;
        if (g) begin
            wait_cyc(6); ps2_clk = 1'b1; wait_cyc(1); ps2_clk = 1'b0; wait_cyc(h - 7);
        end else begin
            wait_cyc(h);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int h, input bit gl);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], h, gl && (i == 2 || i == 5));
        ps2_data = 1'b1;
        wait_cyc(4);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 10, 1'b0);
    endtask

    initial begin
        int e0, zeros, rs, re, c_s;
        wait_cyc(3);
        chk("reset_keys", w_keys, 8'h00);
        chk("reset_err", 8'(frame_err), 8'h00);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(20);

        // Make of W: visible exactly two cycles after the stop edge is acted on
        good(8'h1D);
        c_s = last_fall_c + LAT;
        chk("w_latency_before", 8'(hist_keys[c_s][7]), 8'h00);
        chk("w_latency_after", 8'(hist_keys[c_s + 1][7]), 8'h01);
        chk("w_make", 8'(j1_up), 8'h01);
        good(8'hF0); good(8'h1D);
        chk("w_break", 8'(j1_up), 8'h00);

        good(8'h1D);
        good(8'hE0); good(8'h75);
        chk("up_arrow_make", 8'(j2_up), 8'h01);
        chk("w_kept", 8'(j1_up), 8'h01);
        good(8'hE0); good(8'hF0); good(8'h75);
        chk("up_arrow_break", 8'(j2_up), 8'h00);
        chk("w_still", 8'(j1_up), 8'h01);

        e0 = errcnt;
        send_frame(8'h23, 1'b1, 1'b0, 11, 10, 1'b0);
        chk("badpar_pulses", 8'(errcnt - e0), 8'h01);
        chk("badpar_d", 8'(j1_right), 8'h00);
        good(8'h23);
        chk("d_make", 8'(j1_right), 8'h01);

        good(8'hF0);
        e0 = errcnt;
        send_frame(8'h1C, 1'b0, 1'b0, 3, 10, 1'b0);
        wait_cyc(TO + LAT + 10);
        chk("timeout_pulses", 8'(errcnt - e0), 8'h01);
        good(8'h1C);
        chk("a_after_timeout", 8'(j1_left), 8'h01);

        good(8'h1B);
        rs = cyc;
        for (int i = 0; i < 10; i++) good(8'h1D);
        re = cyc;
        zeros = 0;
        for (int c = rs; c < re; c++) if (hist_keys[c][7:6] != 2'b11) zeros = zeros + 1;
        chk("typematic_glitch", 8'(zeros), 8'h00);
        chk("typematic_held", 8'({j1_up, j1_down}), 8'h03);

        e0 = errcnt;
        send_frame(8'hF0, 1'b0, 1'b0, 11, 11, 1'b1);
        send_frame(8'h1D, 1'b0, 1'b0, 11, 12, 1'b1);
        chk("glitch_w_break", 8'(j1_up), 8'h00);
        send_frame(8'hE0, 1'b0, 1'b0, 11, 10, 1'b1);
        send_frame(8'h72, 1'b0, 1'b0, 11, 11, 1'b1);
        chk("glitch_down_arrow", 8'(j2_down), 8'h01);
        chk("glitch_no_err", 8'(errcnt - e0), 8'h00);

        e0 = errcnt;
        send_frame(8'h1C, 1'b0, 1'b0, 5, 10, 1'b0);
        wait_cyc(LAT);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(20);
        chk("midreset_keys", w_keys, 8'h00);
        wait_cyc(TO + 20);
        chk("midreset_no_err", 8'(errcnt - e0), 8'h00);
        good(8'h1C);
        chk("a_after_reset", 8'(j1_left), 8'h01);

        for (int f = 0; f < 120; f++) begin
            logic [7:0] b;
            int r, er, h, nb;
            bit gl;
            r = int'($urandom_range(0, 15));
            b = (r < 13) ? pool[r] : 8'($urandom);
            er = int'($urandom_range(0, 19));
            h = int'($urandom_range(8, 12));
            gl = (h >= 10) && ($urandom_range(0, 3) == 0);
            nb = (er == 2) ? int'($urandom_range(1, 10)) : 11;
            send_frame(b, er == 0, er == 1, nb, h, gl);
            if (er == 2) wait_cyc(TO + LAT + 10);
            else         wait_cyc(int'($urandom_range(2, 30)));
        end

        wait_cyc(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decodeur_clavier.md
DECODEUR_CLAVIER -- requirements
Module: decodeur_clavier

Interface
REQ-001 Parameter FILTER_LEN, default 4, number of consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 Parameter TIMEOUT, default 50000, clk cycles without an accepted ps2_clk falling edge after which a partial frame is abandoned.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_clk  in  1  keyboard clock, asynchronous to clk.
REQ-006 ps2_data  in  1  keyboard data, asynchronous to clk.
REQ-007 j1_up  out  1  player 1 up key (W, code 0x1D) held.
REQ-008 j1_down  out  1  player 1 down key (S, code 0x1B) held.
REQ-009 j1_left  out  1  player 1 left key (A, code 0x1C) held.
REQ-010 j1_right  out  1  player 1 right key (D, code 0x23) held.
REQ-011 j2_up  out  1  player 2 up arrow (E0 0x75) held.
REQ-012 j2_down  out  1  player 2 down arrow (E0 0x72) held.
REQ-013 j2_left  out  1  player 2 left arrow (E0 0x6B) held.
REQ-014 j2_right  out  1  player 2 right arrow (E0 0x74) held.
REQ-015 frame_err  out  1  one-cycle pulse on a discarded frame.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; the filtered clock level SHALL change only after FILTER_LEN equal consecutive synchronized samples.
REQ-017 A falling edge SHALL be the filtered clock changing 1->0; synchronized ps2_data SHALL be sampled in that same cycle.
REQ-018 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: on an edge with data 0 (start) -> DATA, bit count 0; on an edge with data 1 -> stay in IDLE, no error.
REQ-020 DATA: 8 edges shift data in LSB first -> PARITY after the 8th.
REQ-021 PARITY: the sampled bit plus the 8 data bits SHALL have odd parity; the result is recorded and the FSM moves to STOP.
REQ-022 STOP: stop bit 1 with correct parity -> byte valid; stop bit 0 or wrong parity -> discard byte and assert frame_err; IDLE in both cases.
REQ-023 The internal byte-valid strobe SHALL be asserted the cycle after the stop-bit edge; frame_err SHALL be asserted on that same cycle.
REQ-024 In DATA, PARITY or STOP, if no edge is accepted for TIMEOUT cycles, the FSM SHALL return to IDLE and pulse frame_err once.
REQ-025 The decoder SHALL keep two prefix flags, ext and brk: byte 0xE0 sets ext, byte 0xF0 sets brk, and any other valid byte is a key byte that is applied and then clears both flags.
REQ-026 Key byte with ext=0 matching the player 1 map: brk=0 sets the flag, brk=1 clears it.
REQ-027 Key byte with ext=1 matching the player 2 map: brk=0 sets the flag, brk=1 clears it.
REQ-028 Unmapped key bytes, a player 1 code with ext=1, a player 2 code with ext=0, and bytes 0xAA, 0xFA, 0xE1 SHALL change no output and SHALL clear both prefix flags.
REQ-029 Direction outputs SHALL be registered and change the cycle after the byte-valid strobe, i.e. 2 cycles after the stop-bit edge.
REQ-030 Any frame_err pulse SHALL clear ext and brk and leave the direction outputs unchanged.
REQ-031 Opposite directions held together (e.g. up and down) SHALL both read 1; no arbitration.
REQ-032 A repeated make code (typematic) for an already-held key SHALL keep the flag at 1 with no glitch.

Reset
REQ-033 While reset=1, on each clk edge: all direction outputs and frame_err SHALL be 0, the FSM SHALL be in IDLE, ext=brk=0, and the filter, synchronizer, bit counter and timeout counter SHALL be cleared.
REQ-034 Reset asserted mid-frame SHALL drop the partial byte without pulsing frame_err; reception SHALL restart at the next start bit after reset is released.

Verification
REQ-035 Frame 0x1D, correct parity -> j1_up=1 exactly 2 cycles after the stop edge; frames F0,1D -> j1_up=0.
REQ-036 Frames E0,75 -> j2_up=1 and j1_up unchanged; frames E0,F0,75 -> j2_up=0.
REQ-037 Frame 0x23 with even parity -> frame_err pulses once, j1_right stays 0, and the next correct 0x23 sets j1_right=1.
REQ-038 Frame F0, then TIMEOUT cycles with no edges after 3 bits of a new frame -> one frame_err pulse, brk cleared, so a following 0x1C sets j1_left=1.
REQ-039 Hold 0x1D and 0x1B together, then send 0x1D ten times -> j1_up=j1_down=1 throughout, with no 0 glitch.
REQ-040 1-cycle glitches on ps2_clk (shorter than FILTER_LEN) during a frame -> no extra bits and the correct byte is decoded.
